// File: rtl/gnn_pkg.sv
// gnn_pkg: shared constants and state type for the GNN input loader
package gnn_pkg;
  localparam int WORD_W     = 5;
  localparam int N_X        = 16;
  localparam int N_W        = 24;
  localparam int N_DONE     = 8;
  localparam int FRAME_FULL = 40;
  localparam int FRAME_X    = 16;
  localparam int W2_START   = 32;
  typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;
endpackage

// File: rtl/gnn_done_tracker.sv
// gnn_done_tracker: sticky collection of output-ready flags with a bounded wait timer
module gnn_done_tracker #(
  parameter int N_DONE  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [N_DONE-1:0] i_flags,
  output logic              o_all_done,
  output logic              o_timeout
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [N_DONE-1:0] r_sticky, w_acc;
  logic [TW-1:0]     r_tcnt;
  assign w_acc      = r_sticky | i_flags;
  assign o_all_done = i_en && (&w_acc);
  assign o_timeout  = i_en && !(&w_acc) && (r_tcnt == TW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
      r_tcnt   <= '0;
    end else if (i_clear) begin
      r_sticky <= i_flags;
      r_tcnt   <= '0;
    end else if (i_en) begin
      r_sticky <= w_acc;
      r_tcnt   <= r_tcnt + TW'(1);
    end
  end
endmodule

// File: rtl/gnn_input_loader.sv
// gnn_input_loader: stages a serial feature/weight stream and presents committed frames to the GNN
module gnn_input_loader
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WORD_W-1:0]       s_data,
  input  logic                    s_last,
  input  logic                    x_only,
  output logic [N_X*WORD_W-1:0]   x_flat,
  output logic [N_W*WORD_W-1:0]   w_flat,
  output logic                    in_ready,
  input  logic [N_DONE-1:0]       done_flags,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    timeout_err
);
  localparam int SW = FRAME_FULL * WORD_W;
  localparam int XW = N_X * WORD_W;
  state_t          r_state, w_next;
  logic [5:0]      r_cnt, w_last_idx;
  logic            r_xo, w_xo, w_xfer, w_at_last, w_fire, w_bad, w_done, w_to, r_frame_err;
  logic [SW-1:0]   r_stage, w_merged;
  logic [XW-1:0]   r_x;
  logic [SW-XW-1:0] r_w;
  assign s_ready     = (r_state == LOAD) && !rst;
  assign w_xfer      = s_valid && s_ready;
  // frame mode comes straight from the input on word 0, from the latch afterwards
  assign w_xo        = (r_cnt == 6'd0) ? x_only : r_xo;
  assign w_last_idx  = w_xo ? 6'(FRAME_X - 1) : 6'(FRAME_FULL - 1);
  assign w_at_last   = (r_cnt == w_last_idx);
  assign w_fire      = w_xfer && w_at_last && s_last;
  assign w_bad       = w_xfer && (w_at_last != s_last);
  assign x_flat      = r_x;
  assign w_flat      = r_w;
  assign in_ready    = (r_state == FIRE);
  assign busy        = (r_state != LOAD);
  assign frame_err   = r_frame_err;
  assign timeout_err = w_to;
  // commit sees the final word in the same edge it is accepted
  always_comb begin
    w_merged = r_stage;
    if (w_xfer) w_merged[r_cnt*WORD_W +: WORD_W] = s_data;
  end
  always_comb begin
    w_next = (r_state == LOAD) ? (w_fire ? FIRE : LOAD) :
             (r_state == FIRE) ? WAIT :
             (w_done || w_to)  ? LOAD : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_xo        <= 1'b0;
      r_stage     <= '0;
      r_x         <= '0;
      r_w         <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_frame_err <= w_bad;
      if (w_xfer) begin
        r_stage <= w_merged;
        r_cnt   <= (w_fire || w_bad) ? 6'd0 : r_cnt + 6'd1;
      end
      if (w_xfer && r_cnt == 6'd0) r_xo <= x_only;
      if (w_fire) begin
        r_x <= w_merged[XW-1:0];
        if (!w_xo) r_w <= w_merged[SW-1:XW];
      end
    end
  end
  gnn_done_tracker #(.N_DONE(N_DONE), .TIMEOUT(TIMEOUT)) u_done (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == FIRE),
    .i_en       (r_state == WAIT),
    .i_flags    (done_flags),
    .o_all_done (w_done),
    .o_timeout  (w_to)
  );
endmodule
